// File: rtl/uart_tx_arbiter_if.sv
// Byte-source and UART-side signals of the two-source UART transmit arbiter.
// The slave modport is the arbiter's view; the master modport is the sources' and UART's view.
interface uart_tx_arbiter_if;
    logic       req0_valid;
    logic [7:0] req0_byte;
    logic       req0_last;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_byte;
    logic       req1_last;
    logic       req1_ready;
    logic       is_transmitting;
    logic [7:0] tx_byte;
    logic       transmit;
    logic [1:0] grant;
    logic       pkt_abort;

    modport slave (
        input  req0_valid, req0_byte, req0_last,
        input  req1_valid, req1_byte, req1_last,
        input  is_transmitting,
        output req0_ready, req1_ready,
        output tx_byte, transmit, grant, pkt_abort
    );

    modport master (
        output req0_valid, req0_byte, req0_last,
        output req1_valid, req1_byte, req1_last,
        output is_transmitting,
        input  req0_ready, req1_ready,
        input  tx_byte, transmit, grant, pkt_abort
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing one UART transmitter between two
// valid/ready byte sources; a grant is held for a whole packet.
module uart_tx_arbiter #(
    parameter int MAX_PKT_LEN  = 16,
    parameter int IDLE_TIMEOUT = 255
) (
    input logic              clk,
    input logic              rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_PKT_LEN + 1);
    localparam int TMR_W = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PKT_LEN);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(IDLE_TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LIM = TMR_W'(IDLE_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, FETCH, SEND, WAIT_HI, WAIT_LO} state_t;

    state_t           state, state_nxt;
    logic [1:0]       grant_r;
    logic             rr_last;
    logic [CNT_W-1:0] byte_cnt;
    logic [TMR_W-1:0] idle_tmr;
    logic             last_q;
    logic [7:0]       tx_byte_r;
    logic             pkt_abort_r;

    logic       any_valid, pick1, sel_valid, sel_last, pkt_done, tmr_expired;
    logic [7:0] sel_byte;
    logic       ready0, ready1, transmit, start, accept, release_grant, abort;

    function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [TMR_W-1:0] sat_tmr(input logic [TMR_W-1:0] v);
        return (v == TMR_MAX) ? v : v + TMR_W'(1);
    endfunction

    assign any_valid   = bus.req0_valid | bus.req1_valid;
    // On a tie, favour the source that was not served last.
    assign pick1       = bus.req1_valid & (~bus.req0_valid | ~rr_last);
    assign sel_valid   = grant_r[1] ? bus.req1_valid : bus.req0_valid;
    assign sel_byte    = grant_r[1] ? bus.req1_byte  : bus.req0_byte;
    assign sel_last    = grant_r[1] ? bus.req1_last  : bus.req0_last;
    assign pkt_done    = last_q | (byte_cnt == CNT_MAX);
    assign tmr_expired = (idle_tmr == TMR_LIM);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_valid) state_nxt = FETCH;
            FETCH: begin
                if (sel_valid)        state_nxt = SEND;
                else if (tmr_expired) state_nxt = IDLE;
            end
            SEND:    state_nxt = WAIT_HI;
            WAIT_HI: if (bus.is_transmitting) state_nxt = WAIT_LO;
            WAIT_LO: if (!bus.is_transmitting) state_nxt = pkt_done ? IDLE : FETCH;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready0        = 1'b0;
        ready1        = 1'b0;
        transmit      = 1'b0;
        start         = 1'b0;
        accept        = 1'b0;
        release_grant = 1'b0;
        abort         = 1'b0;
        case (state)
            IDLE:  start = any_valid;
            FETCH: begin
                ready0 = grant_r[0] & bus.req0_valid;
                ready1 = grant_r[1] & bus.req1_valid;
                accept = ready0 | ready1;
                if (!sel_valid && tmr_expired) begin
                    release_grant = 1'b1;
                    abort         = 1'b1;
                end
            end
            SEND:    transmit = 1'b1;
            WAIT_LO: begin
                if (!bus.is_transmitting && pkt_done) begin
                    release_grant = 1'b1;
                    abort         = ~last_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_r     <= 2'b00;
            rr_last     <= 1'b1;
            byte_cnt    <= '0;
            idle_tmr    <= '0;
            last_q      <= 1'b0;
            tx_byte_r   <= 8'h00;
            pkt_abort_r <= 1'b0;
        end else begin
            pkt_abort_r <= abort;
            if (start) begin
                grant_r  <= pick1 ? 2'b10 : 2'b01;
                byte_cnt <= '0;
                idle_tmr <= '0;
            end else if (accept) begin
                tx_byte_r <= sel_byte;
                last_q    <= sel_last;
                byte_cnt  <= sat_cnt(byte_cnt);
                idle_tmr  <= '0;
            end else if (state == FETCH) begin
                idle_tmr <= sat_tmr(idle_tmr);
            end
            // rr_last remembers the owner whose packet just ended, however it ended.
            if (release_grant) begin
                grant_r <= 2'b00;
                rr_last <= grant_r[1];
            end
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.transmit   = transmit;
    assign bus.tx_byte    = tx_byte_r;
    assign bus.grant      = grant_r;
    assign bus.pkt_abort  = pkt_abort_r;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: two instances (long packets / MAX_PKT_LEN=4)
// share the stimulus; a mux selects which one the sources, UART model and monitor observe.
module tb_uart_tx_arbiter;
    localparam int TO = 20;

    typedef struct packed { logic [7:0] b; logic l; } src_t;
    typedef struct packed { logic [1:0] g; logic [7:0] b; } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       v0 = 0, l0 = 0, v1 = 0, l1 = 0, busy = 0, sel = 0;
    logic [7:0] b0 = 0, b1 = 0;
    logic       r0, r1, transmit, pkt_abort;
    logic [7:0] tx_byte;
    logic [1:0] grant;

    src_t q0[$];
    src_t q1[$];
    exp_t expq[$];
    int   vectors = 0, miscompares = 0, tx_count = 0, aborts = 0, busy_len = 10;

    uart_tx_arbiter_if ifa ();
    uart_tx_arbiter_if ifb ();

    uart_tx_arbiter #(.MAX_PKT_LEN(16), .IDLE_TIMEOUT(TO)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    uart_tx_arbiter #(.MAX_PKT_LEN(4),  .IDLE_TIMEOUT(TO)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    assign ifa.req0_valid = v0;  assign ifb.req0_valid = v0;
    assign ifa.req0_byte  = b0;  assign ifb.req0_byte  = b0;
    assign ifa.req0_last  = l0;  assign ifb.req0_last  = l0;
    assign ifa.req1_valid = v1;  assign ifb.req1_valid = v1;
    assign ifa.req1_byte  = b1;  assign ifb.req1_byte  = b1;
    assign ifa.req1_last  = l1;  assign ifb.req1_last  = l1;
    assign ifa.is_transmitting = busy;
    assign ifb.is_transmitting = busy;

    assign r0        = sel ? ifb.req0_ready : ifa.req0_ready;
    assign r1        = sel ? ifb.req1_ready : ifa.req1_ready;
    assign transmit  = sel ? ifb.transmit   : ifa.transmit;
    assign tx_byte   = sel ? ifb.tx_byte    : ifa.tx_byte;
    assign grant     = sel ? ifb.grant      : ifa.grant;
    assign pkt_abort = sel ? ifb.pkt_abort  : ifa.pkt_abort;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic enq(input int src, input logic [7:0] b, input logic l, input logic expect_tx);
        src_t s;
        exp_t e;
        s.b = b;
        s.l = l;
        e.g = (src == 1) ? 2'b10 : 2'b01;
        e.b = b;
        if (src == 1) q1.push_back(s);
        else          q0.push_back(s);
        if (expect_tx) expq.push_back(e);
    endtask

    task automatic wait_drain(input string name, input int limit);
        int n = 0;
        while ((expq.size() != 0 || q0.size() != 0 || q1.size() != 0 || grant != 2'b00) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(name, (n >= limit), 0);
    endtask

    task automatic wait_grant(input logic [1:0] g, input string name);
        int n = 0;
        while (grant != g && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, grant, g);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    // Sources: present queue heads, pop on the edge after ready was seen high.
    initial begin
        logic a0, a1;
        forever begin
            @(negedge clk);
            a0 = r0;
            a1 = r1;
            @(posedge clk);
            #1;
            if (a0 && q0.size() > 0) void'(q0.pop_front());
            if (a1 && q1.size() > 0) void'(q1.pop_front());
            if (q0.size() > 0) begin v0 = 1; b0 = q0[0].b; l0 = q0[0].l; end
            else               begin v0 = 0; b0 = 8'h00; l0 = 0; end
            if (q1.size() > 0) begin v1 = 1; b1 = q1[0].b; l1 = q1[0].l; end
            else               begin v1 = 0; b1 = 8'h00; l1 = 0; end
        end
    end

    // UART model: busy rises the cycle after a strobe and stays up busy_len cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && transmit) begin
                @(posedge clk);
                #1 busy = 1'b1;
                repeat (busy_len) @(posedge clk);
                #1 busy = 1'b0;
            end
        end
    end

    // Monitor: scoreboard pops on every strobe, plus handshake and abort-pulse rules.
    initial begin
        logic outstanding = 0, seen_hi = 0, prev_tx = 0, prev_abort = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                outstanding = 0;
                prev_tx     = 0;
                prev_abort  = 0;
            end else begin
                if (transmit) begin
                    check("xmit_spacing", {prev_tx, outstanding}, 0);
                    if (expq.size() == 0) begin
                        check("xmit_unexpected", {24'h0, tx_byte}, 32'hffff_ffff);
                    end else begin
                        e = expq.pop_front();
                        check("xmit_byte", tx_byte, e.b);
                        check("xmit_grant", grant, e.g);
                    end
                    tx_count++;
                    outstanding = 1;
                    seen_hi     = 0;
                end else if (outstanding) begin
                    if (busy)         seen_hi = 1;
                    else if (seen_hi) outstanding = 0;
                end
                if (pkt_abort) begin
                    aborts++;
                    check("abort_grant", grant, 2'b00);
                    check("abort_width", prev_abort, 0);
                end
                prev_tx    = transmit;
                prev_abort = pkt_abort;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d vectors so far", vectors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] t1_bytes [14];
        int n;
        t1_bytes = '{8'h55, 8'h12, 8'h23, 8'h34, 8'h45, 8'h56, 8'h67,
                     8'h78, 8'h89, 8'h9a, 8'hab, 8'hbc, 8'hcd, 8'haa};

        repeat (3) @(negedge clk);
        check("rst_tx_byte", tx_byte, 8'h00);
        check("rst_transmit", transmit, 0);
        check("rst_grant", grant, 2'b00);
        check("rst_pkt_abort", pkt_abort, 0);
        check("rst_ready0", r0, 0);
        check("rst_ready1", r1, 0);
        rst = 1'b1;

        // Single 14-byte packet from source 0
        tx_count = 0; aborts = 0;
        for (int i = 0; i < 14; i++) enq(0, t1_bytes[i], (i == 13), 1);
        wait_drain("t1_drain", 2000);
        check("t1_tx_count", tx_count, 14);
        check("t1_aborts", aborts, 0);

        // Tie after reset, then strict alternation
        do_reset();
        tx_count = 0; aborts = 0;
        enq(0, 8'h10, 0, 1); enq(0, 8'h11, 1, 1);
        enq(1, 8'h20, 0, 1); enq(1, 8'h21, 1, 1);
        enq(0, 8'h12, 0, 1); enq(0, 8'h13, 1, 1);
        enq(1, 8'h22, 0, 1); enq(1, 8'h23, 1, 1);
        wait_drain("t2_drain", 2000);
        check("t2_tx_count", tx_count, 8);
        check("t2_aborts", aborts, 0);

        // Idle timeout on source 1 while source 0 waits
        tx_count = 0; aborts = 0;
        enq(1, 8'h3c, 0, 1);
        wait_grant(2'b10, "t3_grant1");
        enq(0, 8'hc3, 1, 1);
        n = 0;
        while (!busy && n < 200) begin @(negedge clk); n++; end
        while (busy && n < 400) begin @(negedge clk); n++; end
        n = 0;
        do begin @(negedge clk); n++; end while (!pkt_abort && n < 100);
        check("t3_abort_delay", n, TO + 1);
        wait_drain("t3_drain", 1000);
        check("t3_tx_count", tx_count, 2);
        check("t3_aborts", aborts, 1);

        // Long UART busy time
        busy_len = 50;
        tx_count = 0; aborts = 0;
        enq(0, 8'h71, 0, 1); enq(0, 8'h72, 0, 1); enq(0, 8'h73, 1, 1);
        wait_drain("t5_drain", 2000);
        check("t5_tx_count", tx_count, 3);
        busy_len = 10;

        // Reset during WAIT_LO of byte 3
        tx_count = 0; aborts = 0;
        enq(0, 8'h81, 0, 1); enq(0, 8'h82, 0, 1); enq(0, 8'h83, 0, 1);
        enq(0, 8'h84, 0, 0); enq(0, 8'h85, 1, 0);
        n = 0;
        while (tx_count < 3 && n < 500) begin @(negedge clk); n++; end
        while (!busy && n < 600) begin @(negedge clk); n++; end
        @(negedge clk);
        check("t6_in_wait_lo", {busy, grant}, 3'b101);
        #1 rst = 1'b0;
        #1;
        check("t6_rst_tx_byte", tx_byte, 8'h00);
        check("t6_rst_transmit", transmit, 0);
        check("t6_rst_grant", grant, 2'b00);
        check("t6_rst_ready0", r0, 0);
        q0.delete();
        q1.delete();
        enq(0, 8'h90, 1, 1);
        enq(1, 8'ha0, 1, 1);
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t6_tie_grant", grant, 2'b01);
        wait_drain("t6_drain", 1000);
        check("t6_tx_count", tx_count, 5);
        check("t6_aborts", aborts, 0);

        // Length limit on the MAX_PKT_LEN=4 instance
        sel = 1'b1;
        do_reset();
        tx_count = 0; aborts = 0;
        for (int i = 0; i < 6; i++) enq(0, 8'h41 + 8'(i), 0, 1);
        wait_drain("t4_drain", 2000);
        check("t4_tx_count", tx_count, 6);
        check("t4_aborts", aborts, 2);

        // last on the MAX_PKT_LEN-th byte is a normal end
        tx_count = 0; aborts = 0;
        for (int i = 0; i < 4; i++) enq(0, 8'h51 + 8'(i), (i == 3), 1);
        wait_drain("t4b_drain", 2000);
        check("t4b_tx_count", tx_count, 4);
        check("t4b_aborts", aborts, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
